// File: rtl/uart_pkg.sv
// Shared UART receive definitions: frame constants, rx FSM state encoding, bit-timing helper.
// UART_RX_PARITY_EN adds the even-parity state to the FSM encoding.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;
`endif

  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_top_if.sv
// Receive-side bundle: serial line in, assembled word and status strobes out.
// slave = the receiver, master = whoever drives rxd and consumes the word.
interface uart_rx_top_if #(
  parameter int NUM_BYTES = 16
);
  logic                   rxd;
  logic [8*NUM_BYTES-1:0] data_out;
  logic                   valid;
  logic                   frame_err;
  logic                   timeout_err;

  modport slave  (input rxd,  output data_out, output valid, output frame_err, output timeout_err);
  modport master (output rxd, input  data_out, input  valid, input  frame_err, input  timeout_err);
endinterface

// File: rtl/uart_rx_byte.sv
// Single-frame receiver: 2-flop sync, mid-bit sampling FSM, registered byte/valid/err strobes.
// Stop bit sampled 2 + 9.5 bit-times after the rxd start edge; no backpressure (strobes are one cycle).
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       rx_idle,
  output logic       rx_fall
);

  localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(half_bit(CLKS_PER_BIT) - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic          rx_meta, rxs;
  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d, byte_q, byte_d;
  logic          vld_q, vld_d, err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  // IDLE is only ever entered with rxs high, so a low rxs there is the falling edge.
  // The start counter begins at 1 because the edge cycle itself has already elapsed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rxs == START_BIT) begin
          state_d = RX_START;
          cnt_d   = CW'(1);
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = (rxs == START_BIT) ? RX_DATA : RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs != ^shift_q) begin
            err_d   = 1'b1;
            state_d = RX_WAIT_HIGH;
          end else begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs == STOP_BIT) begin
            vld_d   = 1'b1;
            byte_d  = shift_q;
            state_d = RX_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rxs == STOP_BIT) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_out   = byte_q;
  assign byte_valid = vld_q;
  assign byte_err   = err_q;
  assign rx_idle    = (state_q == RX_IDLE);
  assign rx_fall    = rx_idle && (rxs == START_BIT);

endmodule

// File: rtl/uart_rx_top.sv
// Assembles NUM_BYTES UART frames into one word; byte i = frame i; valid one cycle after data_out updates.
// No backpressure: strobes are single-cycle. UART_RX_PARITY_EN selects 11-bit frames with even parity.
module uart_rx_top
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int NUM_BYTES    = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_top_if.slave bus
);

  localparam int             W        = 8 * NUM_BYTES;
  localparam int             BCW      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BCW-1:0] BC_LAST  = BCW'(NUM_BYTES - 1);
  localparam int             TO_CYC   = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int             TW       = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0]  TO_LIMIT = TW'(TO_CYC);

  logic [7:0]     rx_byte;
  logic           rx_vld, rx_err, rx_idle, rx_fall;
  logic [W-1:0]   shadow_q, data_q, word_next;
  logic [BCW-1:0] byte_cnt_q;
  logic [TW-1:0]  to_cnt_q;
  logic           done_q, valid_q, ferr_q, tout_q;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (bus.rxd),
    .byte_out   (rx_byte),
    .byte_valid (rx_vld),
    .byte_err   (rx_err),
    .rx_idle    (rx_idle),
    .rx_fall    (rx_fall)
  );

  always_comb begin
    word_next = shadow_q;
    word_next[byte_cnt_q*8 +: 8] = rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q   <= '0;
      data_q     <= '0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      valid_q <= done_q;
      ferr_q  <= 1'b0;
      tout_q  <= 1'b0;

      if (rx_err) begin
        ferr_q     <= 1'b1;
        byte_cnt_q <= '0;
      end else if (rx_vld) begin
        if (byte_cnt_q == BC_LAST) begin
          data_q     <= word_next;
          done_q     <= 1'b1;
          byte_cnt_q <= '0;
        end else begin
          shadow_q   <= word_next;
          byte_cnt_q <= byte_cnt_q + 1'b1;
        end
      end else if (to_cnt_q == TO_LIMIT) begin
        tout_q     <= 1'b1;
        byte_cnt_q <= '0;
      end

      // Idle timer only runs while a partial word is pending between frames.
      if (rx_fall || !rx_idle || byte_cnt_q == '0 || to_cnt_q == TO_LIMIT)
        to_cnt_q <= '0;
      else
        to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.valid       = valid_q;
  assign bus.frame_err   = ferr_q;
  assign bus.timeout_err = tout_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: serial driver plus a queue-based word model.
module tb_uart_rx_top;

  localparam int C  = 64;
  localparam int NB = 16;
  localparam int TB = 32;
  localparam int W  = 8 * NB;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LAT    = 2 + (19 * C + 1) / 2 + 2 + PAR * C;
  localparam int TO_CYC = TB * C;
  localparam logic [W-1:0] LOOP_VEC = 128'h00FF_55AA_0123_4567_89AB_CDEF_0F0F_F0F0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_top_if #(.NUM_BYTES(NB)) bus ();

  uart_rx_top #(
    .CLKS_PER_BIT (C),
    .NUM_BYTES    (NB),
    .TIMEOUT_BITS (TB)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pulse counts and the word/time of the latest pulses.
  int got_valid = 0, got_ferr = 0, got_tout = 0, bad_coinc = 0;
  int valid_cyc = 0, tout_cyc = 0;
  logic [W-1:0] got_word = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid) begin
        got_valid++;
        got_word  = bus.data_out;
        valid_cyc = cyc;
      end
      if (bus.frame_err) got_ferr++;
      if (bus.timeout_err) begin
        got_tout++;
        tout_cyc = cyc;
      end
      if ((bus.valid && bus.frame_err) || (bus.frame_err && bus.timeout_err)) bad_coinc++;
    end
  end

  // Reference model: accepted bytes queue up; a full queue becomes the expected word.
  logic [7:0]   mq[$];
  logic [W-1:0] exp_word = '0;
  int exp_valid = 0, exp_ferr = 0, exp_tout = 0;
  int start_cyc = 0;
  int n_tests = 0, n_fail = 0;

  function automatic void model_good(input logic [7:0] b);
    mq.push_back(b);
    if (mq.size() == NB) begin
      for (int i = 0; i < NB; i++) exp_word[8*i +: 8] = mq[i];
      mq.delete();
      exp_valid++;
    end
  endfunction

  task automatic drive_bit(input logic b);
    bus.rxd = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    if (n > 0) begin
      bus.rxd = 1'b1;
      repeat (n * C) @(posedge clk);
      #1;
      if (mq.size() != 0 && n >= TB) begin
        mq.delete();
        exp_tout++;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int bad_stop_bits);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b);
`endif
    if (bad_stop_bits == 0) begin
      drive_bit(1'b1);
      model_good(b);
    end else begin
      repeat (bad_stop_bits) drive_bit(1'b0);
      drive_bit(1'b1);
      mq.delete();
      exp_ferr++;
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input int max_gap);
    for (int i = 0; i < NB; i++) begin
      send_frame(w[8*i +: 8], 0);
      if (i != NB - 1) idle_bits($urandom_range(0, max_gap));
    end
  endtask

  task automatic wait_valid(input int target, output bit ok);
    for (int k = 0; k < 4 * C && got_valid < target; k++) @(posedge clk);
    @(posedge clk);
    #1;
    ok = (got_valid >= target);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  task automatic test_reset();
    bus.rxd = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (bus.data_out !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", bus.data_out); end
    n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
    n_tests++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got=%b exp=0", bus.frame_err); end
    n_tests++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_tout got=%b exp=0", bus.timeout_err); end
    rst_n = 1'b1;
    idle_bits(2);
  endtask

  task automatic test_glitch_and_basic();
    bit ok;
    logic [W-1:0] w;
    int lat;
    bus.rxd = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    idle_bits(3);
    n_tests++; if (got_valid !== exp_valid) begin n_fail++; $display("FAIL glitch_valid got=%0d exp=%0d", got_valid, exp_valid); end
    n_tests++; if (got_ferr !== exp_ferr) begin n_fail++; $display("FAIL glitch_ferr got=%0d exp=%0d", got_ferr, exp_ferr); end
    n_tests++; if (got_tout !== exp_tout) begin n_fail++; $display("FAIL glitch_tout got=%0d exp=%0d", got_tout, exp_tout); end
    for (int i = 0; i < NB; i++) w[8*i +: 8] = 8'h41 + 8'(i);
    for (int i = 0; i < NB; i++) begin
      send_frame(w[8*i +: 8], 0);
      idle_bits(1);
    end
    wait_valid(exp_valid, ok);
    n_tests++; if (!ok || got_valid !== exp_valid) begin n_fail++; $display("FAIL basic_valid_count got=%0d exp=%0d", got_valid, exp_valid); end
    n_tests++; if (got_word !== exp_word) begin n_fail++; $display("FAIL basic_word got=%h exp=%h", got_word, exp_word); end
    n_tests++; if (got_word[7:0] !== 8'h41) begin n_fail++; $display("FAIL basic_byte0 got=%h exp=41", got_word[7:0]); end
    n_tests++; if (got_word[127:120] !== 8'h50) begin n_fail++; $display("FAIL basic_byte15 got=%h exp=50", got_word[127:120]); end
    n_tests++; if (got_ferr !== exp_ferr) begin n_fail++; $display("FAIL basic_ferr got=%0d exp=%0d", got_ferr, exp_ferr); end
    lat = valid_cyc - start_cyc;
    n_tests++; if (lat < LAT - 1 || lat > LAT + 1) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d+-1", lat, LAT); end
  endtask

  task automatic test_frame_err();
    bit ok;
    int lat;
    for (int i = 0; i < 4; i++) begin
      send_frame(8'($urandom), 0);
      idle_bits(1);
    end
    send_frame(8'($urandom), 3);
    idle_bits(1);
    n_tests++; if (got_ferr !== exp_ferr) begin n_fail++; $display("FAIL ferr_count got=%0d exp=%0d", got_ferr, exp_ferr); end
    n_tests++; if (got_valid !== exp_valid) begin n_fail++; $display("FAIL ferr_no_valid got=%0d exp=%0d", got_valid, exp_valid); end
    send_word(LOOP_VEC, 1);
    wait_valid(exp_valid, ok);
    n_tests++; if (!ok || got_valid !== exp_valid) begin n_fail++; $display("FAIL loop_valid_count got=%0d exp=%0d", got_valid, exp_valid); end
    n_tests++; if (got_word !== LOOP_VEC) begin n_fail++; $display("FAIL loop_word got=%h exp=%h", got_word, LOOP_VEC); end
    n_tests++; if (bus.data_out !== exp_word) begin n_fail++; $display("FAIL loop_data_hold got=%h exp=%h", bus.data_out, exp_word); end
    lat = valid_cyc - start_cyc;
    n_tests++; if (lat < LAT - 1 || lat > LAT + 1) begin n_fail++; $display("FAIL loop_latency got=%0d exp=%0d+-1", lat, LAT); end
  endtask

  task automatic test_timeout();
    bit ok;
    int dt;
    for (int i = 0; i < 7; i++) begin
      send_frame(8'($urandom), 0);
      idle_bits($urandom_range(0, 1));
    end
    idle_bits(40);
    n_tests++; if (got_tout !== exp_tout) begin n_fail++; $display("FAIL tout_count got=%0d exp=%0d", got_tout, exp_tout); end
    dt = tout_cyc - start_cyc;
    n_tests++; if (dt < TO_CYC + (9 + PAR) * C || dt > TO_CYC + (10 + PAR) * C + 8) begin
      n_fail++; $display("FAIL tout_time got=%0d exp=%0d..%0d", dt, TO_CYC + (9 + PAR) * C, TO_CYC + (10 + PAR) * C + 8);
    end
    n_tests++; if (bus.data_out !== exp_word) begin n_fail++; $display("FAIL tout_data_hold got=%h exp=%h", bus.data_out, exp_word); end
    n_tests++; if (got_valid !== exp_valid) begin n_fail++; $display("FAIL tout_no_valid got=%0d exp=%0d", got_valid, exp_valid); end
    send_word(rand_word(), 2);
    wait_valid(exp_valid, ok);
    n_tests++; if (!ok || got_valid !== exp_valid) begin n_fail++; $display("FAIL tout_next_valid got=%0d exp=%0d", got_valid, exp_valid); end
    n_tests++; if (got_word !== exp_word) begin n_fail++; $display("FAIL tout_next_word got=%h exp=%h", got_word, exp_word); end
  endtask

  task automatic test_async_reset();
    bit ok;
    int lat;
    logic [7:0] b;
    for (int i = 0; i < 9; i++) send_frame(8'($urandom), 0);
    b = 8'($urandom);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.data_out !== '0) begin n_fail++; $display("FAIL arst_data got=%h exp=0", bus.data_out); end
    n_tests++; if (bus.valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL arst_strobes got=%b%b%b exp=000", bus.valid, bus.frame_err, bus.timeout_err);
    end
    mq.delete();
    exp_word = '0;
    bus.rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_bits(2);
    n_tests++; if (got_valid !== exp_valid || got_ferr !== exp_ferr || got_tout !== exp_tout) begin
      n_fail++; $display("FAIL arst_no_pulse got=%0d/%0d/%0d exp=%0d/%0d/%0d", got_valid, got_ferr, got_tout, exp_valid, exp_ferr, exp_tout);
    end
    send_word(rand_word(), 2);
    wait_valid(exp_valid, ok);
    n_tests++; if (!ok || got_valid !== exp_valid) begin n_fail++; $display("FAIL arst_next_valid got=%0d exp=%0d", got_valid, exp_valid); end
    n_tests++; if (got_word !== exp_word) begin n_fail++; $display("FAIL arst_next_word got=%h exp=%h", got_word, exp_word); end
    lat = valid_cyc - start_cyc;
    n_tests++; if (lat < LAT - 1 || lat > LAT + 1) begin n_fail++; $display("FAIL arst_latency got=%0d exp=%0d+-1", lat, LAT); end
  endtask

  task automatic test_exclusive_pulses();
    n_tests++; if (bad_coinc !== 0) begin n_fail++; $display("FAIL pulse_overlap got=%0d exp=0", bad_coinc); end
    n_tests++; if (got_ferr !== exp_ferr || got_tout !== exp_tout) begin
      n_fail++; $display("FAIL final_err_counts got=%0d/%0d exp=%0d/%0d", got_ferr, got_tout, exp_ferr, exp_tout);
    end
  endtask

  initial begin
    bus.rxd = 1'b1;
    test_reset();
    test_glitch_and_basic();
    test_frame_err();
    test_timeout();
    test_async_reset();
    test_exclusive_pulses();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_top.md
Name: uart_rx_top

Overview:
UART receiver that reassembles a 128-bit word from 16 serial frames, mirroring uart_tx_top. It consumes the txd line and sits directly downstream of the transmitter in loopback benches and in the receive path of the design. Byte 0, the first frame received, lands in data_out[7:0]; byte i lands in data_out[8*i +: 8]. Bit timing is oversampled with mid-bit sampling.

Parameters:
CLKS_PER_BIT, 100, clock cycles per UART bit (100 MHz clk, 1 Mbaud); must be >= 8.
NUM_BYTES, 16, frames per assembled word; data_out width = 8*NUM_BYTES.
TIMEOUT_BITS, 32, idle bit-times allowed mid-word before a partial word is discarded.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rxd  in  1  serial input, idle high, asynchronous to clk
data_out  out  8*NUM_BYTES  assembled word; byte i = frame i
valid  out  1  one-cycle pulse when data_out has been updated
frame_err  out  1  one-cycle pulse on a bad stop bit
timeout_err  out  1  one-cycle pulse when a partial word is dropped

Behaviour:
- Reset: data_out=0, valid=0, frame_err=0, timeout_err=0, byte count=0, FSM=IDLE, synchronizer flops=1.
- rxd passes through a 2-flop synchronizer. All timing below is relative to the synchronized signal (rxs).
- Frame format: start 0, 8 data bits LSB-first, stop 1. Any number of idle-high bits may separate frames.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: a 1->0 transition on rxs resets the bit counter and moves to START.
- START: at count CLKS_PER_BIT/2, rxs is sampled. If it is 1, the edge was a glitch: return to IDLE with no error. If it is 0, go to DATA.
- DATA: 8 samples taken every CLKS_PER_BIT, shifted in LSB-first, then go to STOP.
- STOP: sampled one CLKS_PER_BIT later.
  - rxs=1: store the byte at index byte_cnt, then go to IDLE.
  - rxs=0: pulse frame_err, discard the byte and the partial word, set byte_cnt=0, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1, then go to IDLE. This handles break conditions.
- Word completion: when byte NUM_BYTES-1 is stored, the whole data_out register is updated in the same cycle. valid is asserted the following cycle for exactly 1 cycle, and byte_cnt wraps to 0.
- data_out changes only on word completion and holds between completions. The partial word is held in a separate shadow register.
- Latency: valid rises 2 (sync) + round(9.5*CLKS_PER_BIT) + 2 cycles after the start-bit falling edge of the last frame on rxd, within +/-1 cycle.
- Timeout: the idle-cycle counter runs only in IDLE with byte_cnt != 0. When it reaches TIMEOUT_BITS*CLKS_PER_BIT, timeout_err pulses and byte_cnt=0. The counter clears on any falling edge.
- Asynchronous rst_n mid-frame aborts immediately to the reset values. No pulse is emitted.
- Pulse outputs may coincide only as frame_err/timeout_err never both in one cycle; valid is never asserted with frame_err.

Optional Feature:
UART_RX_PARITY_EN
- Defined: an even-parity bit is inserted between data bit 7 and stop, giving an 11-bit frame. A parity mismatch is handled exactly like a framing error: pulse frame_err, discard the word, go to WAIT_HIGH. Latency grows by CLKS_PER_BIT.
- Undefined: frame is 10 bits and no parity state exists.

Decomposition:
- Package uart_pkg:
  - rx FSM state enum;
  - DATA_BITS=8;
  - START_BIT=1'b0 and STOP_BIT=1'b1 constants;
  - a function computing the half-bit count.
- Sub-module uart_rx_byte: synchronizer, bit FSM, byte_out[7:0] with byte_valid and byte_err strobes.
- uart_rx_top holds the byte counter, shadow register, timeout counter and output registers.

Test Plan:
- Send "ABCDEFGHIJKLMNOP", byte 0 = 'A' = 0x41 on the wire as 0 10000010 1, with 1 idle bit between frames -> one valid pulse; data_out[7:0]=0x41, data_out[127:120]=0x50; frame_err=0.
- Loopback with uart_tx_top, data_in=128'h00FF_55AA_0123_4567_89AB_CDEF_0F0F_F0F0, one start pulse -> data_out equals data_in; valid once; latency within spec.
- 30-cycle low glitch on rxd while idle -> no valid, no errors, byte_cnt stays 0. A following valid 16-frame word is received correctly.
- Frame 5 sent with stop=0, held low for 3 bit-times -> frame_err pulses once. 16 clean frames afterwards produce valid with the new data only.
- Send 7 frames then idle 40 bit-times -> timeout_err at 32 bit-times; data_out keeps its previous value. The next 16 frames assemble correctly.
- rst_n low during frame 10 data bits -> all outputs 0 immediately. A full 16-frame word after release is received correctly.
